// File: rtl/instr_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction register,
// the sequencer and the CPU datapath.
interface instr_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              s;
  logic [15:0]       ir;
  logic              w;
  logic              illegal;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
  logic              write;
  logic [1:0]        vsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        shift;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] sximm8;

  modport master (
    output s, ir,
    input  w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc,
           loads, asel, bsel, shift, ALUop, sximm8
  );

  modport slave (
    input  s, ir,
    output w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc,
           loads, asel, bsel, shift, ALUop, sximm8
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle Moore controller: accepts one instruction on s/w, then steps the
// register file, A/B/C/status loads and ALU controls until it returns to WAIT.
module instr_sequencer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_WR_IMM
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] li_q, li_d;
  logic        illegal_q, illegal_d;

  logic       w_q, w_d;
  logic [2:0] readnum_q, readnum_d;
  logic [2:0] writenum_q, writenum_d;
  logic       write_q, write_d;
  logic [1:0] vsel_q, vsel_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic       asel_q, asel_d;
  logic [1:0] aluop_q, aluop_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  assign opc        = li_q[15:13];
  assign op         = li_q[12:11];
  assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
  assign is_alu     = (opc == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  // Next state, then the Moore outputs of that next state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    li_d       = li_q;
    illegal_d  = illegal_q;
    w_d        = 1'b0;
    readnum_d  = 3'b000;
    writenum_d = 3'b000;
    write_d    = 1'b0;
    vsel_d     = 2'b00;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    aluop_d    = 2'b00;

    case (state_q)
      S_WAIT: begin
        if (bus.s) begin
          state_d   = S_DECODE;
          li_d      = bus.ir;
          illegal_d = 1'b0;
        end
      end
      S_DECODE: begin
        if (is_mov_imm)                state_d = S_WR_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_GET_B;
        else if (is_alu)               state_d = S_GET_A;
        else begin
          state_d   = S_WAIT;
          illegal_d = 1'b1;
        end
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase

    case (state_d)
      S_WAIT:  w_d = 1'b1;
      S_GET_A: begin
        readnum_d = li_q[10:8];
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = li_q[2:0];
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        asel_d  = is_mov_reg;
        aluop_d = is_mov_reg ? 2'b00 : op;
        loads_d = is_cmp;
        loadc_d = !is_cmp;
      end
      S_WR_REG: begin
        writenum_d = li_q[7:5];
        write_d    = 1'b1;
      end
      S_WR_IMM: begin
        writenum_d = li_q[10:8];
        vsel_d     = 2'b10;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT;
      li_q       <= 16'h0000;
      illegal_q  <= 1'b0;
      w_q        <= 1'b1;
      readnum_q  <= 3'b000;
      writenum_q <= 3'b000;
      write_q    <= 1'b0;
      vsel_q     <= 2'b00;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      aluop_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      li_q       <= li_d;
      illegal_q  <= illegal_d;
      w_q        <= w_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      vsel_q     <= vsel_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      aluop_q    <= aluop_d;
    end
  end

  assign bus.w        = w_q;
  assign bus.illegal  = illegal_q;
  assign bus.readnum  = readnum_q;
  assign bus.writenum = writenum_q;
  assign bus.write    = write_q;
  assign bus.vsel     = vsel_q;
  assign bus.loada    = loada_q;
  assign bus.loadb    = loadb_q;
  assign bus.loadc    = loadc_q;
  assign bus.loads    = loads_q;
  assign bus.asel     = asel_q;
  assign bus.bsel     = 1'b0;
  assign bus.shift    = li_q[4:3];
  assign bus.ALUop    = aluop_q;
  assign bus.sximm8   = {{(DATA_W-8){li_q[7]}}, li_q[7:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-decoded instructions checked cycle by cycle.
module tb_instr_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instr_sequencer_if #(.DATA_W(16)) bus ();

  instr_sequencer #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {write, loada, loadb, loadc, loads}
  function automatic logic [4:0] en();
    return {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads};
  endfunction

  // Advance one edge, sample 1ns later and check the single-writer invariant.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", 32'($countones(en()) <= 1), 32'd1);
  endtask

  task automatic accept(input logic [15:0] instr);
    bus.ir = instr;
    bus.s  = 1'b1;
    tick();
    bus.s  = 1'b0;
    chk("dec_w", 32'(bus.w), 32'd0);
    chk("dec_en", 32'(en()), 32'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    bus.s  = 1'b0;
    bus.ir = 16'h0000;

    // 1: reset state, then MOV R0,#7
    #12;
    chk("rst_w", 32'(bus.w), 32'd1);
    chk("rst_en", 32'(en()), 32'd0);
    chk("rst_ill", 32'(bus.illegal), 32'd0);
    chk("rst_vsel", 32'(bus.vsel), 32'd0);
    chk("rst_aluop", 32'(bus.ALUop), 32'd0);
    tick();
    reset = 1'b1;
    accept(16'hD007);
    tick();
    chk("imm_en", 32'(en()), 32'h10);
    chk("imm_wn", 32'(bus.writenum), 32'd0);
    chk("imm_vsel", 32'(bus.vsel), 32'd2);
    chk("imm_sx", 32'(bus.sximm8), 32'h0007);
    tick();
    chk("imm_wdone", 32'(bus.w), 32'd1);

    // 2: MOV R1,#-1 then ADD R6,R0,R2
    accept(16'hD1FF);
    tick();
    chk("neg_sx", 32'(bus.sximm8), 32'hFFFF);
    chk("neg_wn", 32'(bus.writenum), 32'd1);
    chk("neg_wr", 32'(bus.write), 32'd1);
    tick();
    chk("neg_w", 32'(bus.w), 32'd1);
    accept(16'hA0C2);
    tick();
    chk("add_a_en", 32'(en()), 32'h08);
    chk("add_a_rn", 32'(bus.readnum), 32'd0);
    tick();
    chk("add_b_en", 32'(en()), 32'h04);
    chk("add_b_rn", 32'(bus.readnum), 32'd2);
    tick();
    chk("add_x_en", 32'(en()), 32'h02);
    chk("add_x_op", 32'(bus.ALUop), 32'd0);
    chk("add_x_asel", 32'(bus.asel), 32'd0);
    chk("add_x_bsel", 32'(bus.bsel), 32'd0);
    tick();
    chk("add_wr_en", 32'(en()), 32'h10);
    chk("add_wr_wn", 32'(bus.writenum), 32'd6);
    chk("add_wr_vsel", 32'(bus.vsel), 32'd0);
    chk("add_w4", 32'(bus.w), 32'd0);
    tick();
    chk("add_w5", 32'(bus.w), 32'd1);

    // 3: CMP R7,R6,LSL#1 -- never writes
    accept(16'hAF0E);
    tick();
    chk("cmp_a_rn", 32'(bus.readnum), 32'd7);
    chk("cmp_a_wr", 32'(bus.write), 32'd0);
    tick();
    chk("cmp_b_rn", 32'(bus.readnum), 32'd6);
    chk("cmp_b_wr", 32'(bus.write), 32'd0);
    tick();
    chk("cmp_x_en", 32'(en()), 32'h01);
    chk("cmp_x_op", 32'(bus.ALUop), 32'd1);
    chk("cmp_x_sh", 32'(bus.shift), 32'd1);
    tick();
    chk("cmp_w4", 32'(bus.w), 32'd1);
    chk("cmp_end_wr", 32'(bus.write), 32'd0);

    // 4: MOV R3,R0,LSR#1 -- skips GET_A
    accept(16'hC070);
    tick();
    chk("movr_b_en", 32'(en()), 32'h04);
    chk("movr_b_rn", 32'(bus.readnum), 32'd0);
    tick();
    chk("movr_x_en", 32'(en()), 32'h02);
    chk("movr_x_asel", 32'(bus.asel), 32'd1);
    chk("movr_x_op", 32'(bus.ALUop), 32'd0);
    chk("movr_x_sh", 32'(bus.shift), 32'd2);
    tick();
    chk("movr_wr_en", 32'(en()), 32'h10);
    chk("movr_wr_wn", 32'(bus.writenum), 32'd3);
    tick();
    chk("movr_w4", 32'(bus.w), 32'd1);

    // 5: undefined opcode, then a legal accept clears the flag
    accept(16'hE000);
    chk("ill_dec", 32'(bus.illegal), 32'd0);
    tick();
    chk("ill_w", 32'(bus.w), 32'd1);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_en", 32'(en()), 32'd0);
    tick();
    chk("ill_sticky", 32'(bus.illegal), 32'd1);
    accept(16'hD007);
    chk("ill_clr", 32'(bus.illegal), 32'd0);
    tick();
    tick();
    chk("ill_ret_w", 32'(bus.w), 32'd1);

    // 6a: asynchronous reset while in GET_B of an ADD
    accept(16'hA0C2);
    tick();
    tick();
    chk("rb_en", 32'(en()), 32'h04);
    reset = 1'b0;
    #1;
    chk("rb_w", 32'(bus.w), 32'd1);
    chk("rb_en0", 32'(en()), 32'd0);
    tick();
    chk("rb_nowr", 32'(bus.write), 32'd0);
    chk("rb_hold_w", 32'(bus.w), 32'd1);
    reset = 1'b1;
    tick();
    chk("rb_idle_w", 32'(bus.w), 32'd1);
    chk("rb_idle_en", 32'(en()), 32'd0);

    // 6b: s held through MVN R5,R3; ir changes mid-instruction
    bus.ir = 16'hB8A3;
    bus.s  = 1'b1;
    tick();
    chk("mvn_dec_w", 32'(bus.w), 32'd0);
    bus.ir = 16'hD1FF;
    tick();
    chk("mvn_b_en", 32'(en()), 32'h04);
    chk("mvn_b_rn", 32'(bus.readnum), 32'd3);
    tick();
    chk("mvn_x_en", 32'(en()), 32'h02);
    chk("mvn_x_op", 32'(bus.ALUop), 32'd3);
    tick();
    chk("mvn_wr_wn", 32'(bus.writenum), 32'd5);
    chk("mvn_wr_en", 32'(en()), 32'h10);
    tick();
    chk("mvn_w4", 32'(bus.w), 32'd1);
    tick();
    chk("b2b_w", 32'(bus.w), 32'd0);
    bus.s = 1'b0;
    tick();
    chk("b2b_wr_en", 32'(en()), 32'h10);
    chk("b2b_wn", 32'(bus.writenum), 32'd1);
    chk("b2b_sx", 32'(bus.sximm8), 32'hFFFF);
    tick();
    chk("b2b_end_w", 32'(bus.w), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle controller that sequences the CPU datapath (register file, A/B/C pipeline registers, shifter, ALU, status register) for one instruction at a time.
- Sits between the instruction register and the datapath.
- Accepts an instruction on the `s` handshake, decodes it, and drives register-file and load-enable controls cycle by cycle.
- Raises `w` when idle.

Parameters:
- DATA_W, 16, datapath width; `sximm8` is sign-extended to this width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- s  input  1  start request; level-sampled in WAIT only
- ir  input  16  instruction register contents
- w  output  1  1 when in WAIT (ready for a new instruction)
- illegal  output  1  sticky flag: last accepted instruction was undefined
- readnum  output  3  register-file read address
- writenum  output  3  register-file write address
- write  output  1  register-file write enable
- vsel  output  2  writeback mux select: 00 = C, 10 = sximm8 (01/11 reserved, never driven)
- loada  output  1  load enable for A register
- loadb  output  1  load enable for B register
- loadc  output  1  load enable for C register
- loads  output  1  load enable for status (N/V/Z)
- asel  output  1  1 forces the ALU A input to 0
- bsel  output  1  1 selects sximm8 as the ALU B input (always 0 in this revision)
- shift  output  2  shifter op, taken from latched instruction [4:3]
- ALUop  output  2  00 ADD, 01 SUB (CMP), 10 AND, 11 NOT B
- sximm8  output  DATA_W  sign-extended latched instruction [7:0]

Behaviour:
- **Field decoding** (from latched copy `li` of `ir`):
  - opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0].
  - `li` is captured from `ir` on the clock edge that accepts `s`; later changes to `ir` have no effect until the next accept.
- **Legal instructions** (opcode/op):
  - 110/10 MOV imm
  - 110/00 MOV reg
  - 101/00 ADD
  - 101/01 CMP
  - 101/10 AND
  - 101/11 MVN
  - Anything else is illegal.
- **Moore FSM states:** WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
  - WAIT: w=1. If s=1 at the edge, capture `li` and go to DECODE; else stay.
  - DECODE:
    - MOV imm goes to WR_IMM.
    - MOV reg and MVN go to GET_B.
    - ADD, CMP and AND go to GET_A.
    - Illegal goes to WAIT and sets `illegal`.
  - GET_A: readnum=Rn, loada=1; go to GET_B.
  - GET_B: readnum=Rm, loadb=1; go to EXEC.
  - EXEC: bsel=0; ALUop = li[12:11], except MOV reg forces 00 with asel=1. Then:
    - CMP: loads=1, loadc=0; go to WAIT.
    - All others: loadc=1, loads=0; go to WR_REG.
  - WR_REG: writenum=Rd, vsel=00, write=1; go to WAIT.
  - WR_IMM: writenum=Rn, vsel=10, write=1; go to WAIT.
- **Output defaults:** every control not listed for a state is 0. readnum and writenum are 000 unless listed. `shift` and `sximm8` are driven continuously from `li`.
- **Latency** (edges counted from the accepting edge, edge 0; `w` returns high after the edge listed):

  | Instruction | `w` high after |
  |---|---|
  | MOV imm | edge 2 |
  | MOV reg, MVN, CMP | edge 4 |
  | ADD, AND | edge 5 |
  | Illegal | edge 1 |

- **Handshake rules:**
  - `s` is ignored outside WAIT.
  - If `s` is still 1 when WAIT is re-entered, the next instruction is accepted at the first edge in WAIT; back-to-back operation is legal.
  - `illegal` clears on the next accepted instruction, i.e. at the edge entering DECODE.
- **Reset:** `reset`=0 asynchronously forces:
  - state=WAIT, w=1, illegal=0, `li`=0
  - all enables 0, vsel=00, ALUop=00
  - This holds mid-instruction as well; any pending write is abandoned, and no write may occur in the reset cycle.
- **Write-port invariants:** at most one of write/loada/loadb/loadc/loads is 1 in any cycle. `write` is never 1 outside WR_REG/WR_IMM.

Test Plan:
1. Reset low then release, ir=0xD007, s pulsed one cycle:
   - w=1 and all enables 0 out of reset.
   - DECODE then WR_IMM with write=1, writenum=0, vsel=10, sximm8=0x0007.
   - w=1 after edge 2.
2. ir=0xD1FF (MOV R1,#-1):
   - sximm8=0xFFFF, writenum=1 in WR_IMM.
   - Then ir=0xA0C2 (ADD R6,R0,R2): loada with readnum=0, loadb with readnum=2, EXEC loadc=1 ALUop=00, WR_REG writenum=6; w high after edge 5.
3. ir=0xAF0E (CMP R7,R6,LSL#1):
   - EXEC shows loads=1, loadc=0, ALUop=01, shift=01.
   - No write in any cycle; w high after edge 4.
4. ir=0xC070 (MOV R3,R0,LSR#1):
   - No loada cycle; EXEC asel=1, ALUop=00, shift=10.
   - WR_REG writenum=3.
5. Undefined, ir=0xE000:
   - WAIT to DECODE to WAIT, illegal=1, no enables.
   - Next legal instruction clears illegal at its accept edge.
6. Robustness:
   - Assert reset=0 during GET_B of an ADD: w=1 immediately, all enables 0, no write.
   - Hold s=1 across a MVN (ir=0xB8A3): a second instruction is accepted on the first WAIT edge.
   - Change ir mid-instruction: readnum/writenum unaffected.
